// File: rtl/seq_generator.sv
// Serial pattern burst generator: sends PATTERN MSB-first `reps` times with GAP idle cycles between.
// Optional macro SEQ_GEN_PARITY_EN appends an XOR parity bit after each repetition.
module seq_generator #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               GAP     = 2,
  parameter int               CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] reps,
  output logic             Out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
  localparam logic [3:0]       GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
`ifdef SEQ_GEN_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] bit_q, bit_d, bit_nx;
  logic [3:0]       gap_q, gap_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_rep, rep_end;

  assign bit_nx = bit_q - 1'b1;

  // rem_q holds the repetitions still owed after the current one, so reps=0 and reps=1 both load 0
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    rem_d    = rem_q;
    out_d    = 1'b0;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    load_rep = 1'b0;
    rep_end  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          rem_d    = (reps == '0) ? '0 : reps - 1'b1;
          load_rep = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (bit_q != '0) begin
          bit_d   = bit_nx;
          out_d   = PATTERN[bit_nx];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
`ifdef SEQ_GEN_PARITY_EN
          state_d = S_PARITY;
          out_d   = ^PATTERN;
          valid_d = 1'b1;
          busy_d  = 1'b1;
`else
          rep_end = 1'b1;
`endif
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      S_PARITY: rep_end = 1'b1;
`endif
      S_GAP: begin
        busy_d = 1'b1;
        if (gap_q == '0) load_rep = 1'b1;
        else             gap_d    = gap_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (rep_end) begin
      if (rem_q != '0) begin
        rem_d = rem_q - 1'b1;
        if (GAP > 0) begin
          state_d = S_GAP;
          gap_d   = GAP_LAST;
          busy_d  = 1'b1;
        end else begin
          load_rep = 1'b1;
        end
      end else begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
    end

    if (load_rep) begin
      state_d = S_SEND;
      bit_d   = IDX_LAST;
      out_d   = PATTERN[PAT_W-1];
      valid_d = 1'b1;
      busy_d  = 1'b1;
    end
  end

  // ---- stage boundary: control state and registered outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Counters are reloaded on every accepted start, so reset leaves them alone
  always_ff @(posedge clk) begin
    bit_q <= bit_d;
    gap_q <= gap_d;
    rem_q <= rem_d;
  end

  assign Out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: doc/seq_generator.md
SEQ_GENERATOR -- requirements
Module: seq_generator

Interface
REQ-001 SHALL provide parameter PAT_W, default 4, the pattern length in bits (legal 2..16).
REQ-002 SHALL provide parameter PATTERN, default 4'b1011, the bit pattern transmitted MSB first.
REQ-003 SHALL provide parameter GAP, default 2, the number of idle cycles between repetitions (legal 0..15).
REQ-004 SHALL provide parameter CNT_W, default 4, the width of the repetition count.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: a request to begin a burst, sampled on the rising edge.
REQ-008 SHALL have port reps, input, CNT_W bits: the number of pattern repetitions, latched when start is accepted.
REQ-009 SHALL have port Out, output, 1 bit: the registered serial bit stream, which is the feed for the sequence Detector.
REQ-010 SHALL have port valid, output, 1 bit: high when Out carries a pattern or parity bit.
REQ-011 SHALL have port busy, output, 1 bit: high while a burst is in progress.
REQ-012 SHALL have port done, output, 1 bit: a single-cycle pulse marking burst completion.

Function
REQ-013 SHALL implement the states IDLE, SEND, GAP and DONE; PARITY is added only per REQ-027.
REQ-014 SHALL, in IDLE or DONE with start=1 at an edge, latch reps, enter SEND, and drive Out=PATTERN[PAT_W-1] with valid=1 and busy=1 after that same edge (one-edge latency).
REQ-015 SHALL treat reps=0 exactly as reps=1.
REQ-016 SHALL, in SEND, shift out one bit per cycle from bit PAT_W-1 down to bit 0, keeping valid=1.
REQ-017 SHALL, after bit 0, go to GAP when further repetitions remain and GAP>0, back to SEND (bit PAT_W-1) when they remain and GAP=0, or to DONE after the final repetition.
REQ-018 SHALL, in GAP, drive Out=0, valid=0 and busy=1 for exactly GAP cycles, then return to SEND.
REQ-019 SHALL, in DONE, drive done=1, busy=0, valid=0 and Out=0 for exactly one cycle, then go to IDLE unless start=1.
REQ-020 SHALL ignore start while busy=1; reps SHALL NOT be re-latched mid-burst.
REQ-021 SHALL count repetitions in a CNT_W-bit down-counter; a burst with reps=2^CNT_W-1 SHALL complete without wrap-around.
REQ-022 SHALL, in IDLE, drive Out=0, valid=0, busy=0 and done=0.
REQ-023 SHALL make a burst span R*PAT_W + (R-1)*GAP cycles with busy=1, where R is the effective repetition count.

Reset
REQ-024 SHALL, when rst=1 at an edge, enter IDLE and set Out=0, valid=0, busy=0 and done=0, regardless of state.
REQ-025 SHALL abort any burst in progress on reset, discarding the latched reps and the bit and gap counters.
REQ-026 SHALL give rst priority over start on the same edge.

Configuration
REQ-027 SHALL, when macro SEQ_GEN_PARITY_EN is defined, append one PARITY cycle after bit 0 of every repetition, with Out equal to the XOR of PATTERN and valid=1, before the GAP/SEND/DONE decision.
REQ-028 SHALL, when SEQ_GEN_PARITY_EN is undefined, contain no PARITY state, with burst timing per REQ-023.

Verification
REQ-029 SHALL be checked with: PATTERN=1011, reps=1, start for one cycle -> Out 1,0,1,1 with valid=1 on the 4 cycles after the start edge, then done=1 for one cycle, then idle.
REQ-030 SHALL be checked with: reps=2, GAP=2 -> Out/valid 1011/1111, 00/00, 1011/1111, then done pulse; busy high for 10 cycles.
REQ-031 SHALL be checked with: reps=0 -> output identical to the reps=1 case.
REQ-032 SHALL be checked with: start pulsed during the second bit of a burst -> no effect; burst length unchanged.
REQ-033 SHALL be checked with: rst=1 during the third bit of SEND -> after that edge Out=0, valid=0, busy=0, done=0; a later start begins a fresh burst at bit PAT_W-1.
REQ-034 SHALL be checked with: SEQ_GEN_PARITY_EN defined, PATTERN=1011, reps=1 -> Out 1,0,1,1,1 with valid=1 for 5 cycles, then done.
